// File: rtl/prbs_stream_checker.sv
// Receive-side PRBS checker: seeds a local LFSR from the incoming stream, then
// predicts each bit, counts mismatches and re-seeds when the error rate shows lost sync.
module prbs_stream_checker #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
    parameter int               WINDOW      = 64,
    parameter int               LOSS_THRESH = 4,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic             lock_lost
);

    localparam int SEED_W = $clog2(WIDTH + 1);
    localparam int WIN_W  = $clog2(WINDOW);
    localparam int WERR_W = $clog2(LOSS_THRESH + 1) + 1;

    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(WIDTH - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] THRESH    = WERR_W'(LOSS_THRESH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {ST_SEED, ST_LOCKED} state_t;

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    sr_reg, sr_next;
    logic [SEED_W-1:0]   seed_cnt_reg, seed_cnt_next;
    logic [WIN_W-1:0]    win_cnt_reg, win_cnt_next;
    logic [WERR_W-1:0]   win_err_reg, win_err_next;
    logic                locked_reg, locked_next;
    logic                err_pulse_reg, err_pulse_next;
    logic [CNT_W-1:0]    err_count_reg, err_count_next;
    logic [CNT_W-1:0]    bit_count_reg, bit_count_next;
    logic                lock_lost_reg, lock_lost_next;

    logic [WIDTH-1:0]    tapped;
    logic [WIDTH-1:0]    sr_shift_in;
    logic                pred;
    logic                mismatch;
    logic [WERR_W-1:0]   win_err_inc;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_taps
        assign tapped[gi] = sr_reg[gi] & TAPS[gi];
    end

    assign pred        = ^tapped;
    assign mismatch    = bit_in ^ pred;
    assign sr_shift_in = {sr_reg[WIDTH-2:0], bit_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_SEED;
            sr_reg        <= '0;
            seed_cnt_reg  <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
            bit_count_reg <= '0;
            lock_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            seed_cnt_reg  <= seed_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            win_err_reg   <= win_err_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
            bit_count_reg <= bit_count_next;
            lock_lost_reg <= lock_lost_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sr_next        = sr_reg;
        seed_cnt_next  = seed_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        win_err_next   = win_err_reg;
        err_pulse_next = 1'b0;
        err_count_next = err_count_reg;
        bit_count_next = bit_count_reg;
        lock_lost_next = lock_lost_reg;
        win_err_inc    = win_err_reg + WERR_W'(mismatch);

        if (bit_valid) begin
            case (state_reg)
                ST_SEED: begin
                    sr_next = sr_shift_in;
                    if (seed_cnt_reg == SEED_LAST) begin
                        seed_cnt_next = '0;
                        // An all-zero seed would lock the LFSR at zero forever.
                        if (sr_shift_in != '0) begin
                            state_next   = ST_LOCKED;
                            win_cnt_next = '0;
                            win_err_next = '0;
                        end
                    end else begin
                        seed_cnt_next = seed_cnt_reg + SEED_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Feed back the prediction so a flipped bit is never propagated.
                    sr_next        = {sr_reg[WIDTH-2:0], pred};
                    bit_count_next = (bit_count_reg == CNT_MAX) ? bit_count_reg
                                                                : bit_count_reg + CNT_W'(1);
                    if (mismatch) begin
                        err_pulse_next = 1'b1;
                        err_count_next = (err_count_reg == CNT_MAX) ? err_count_reg
                                                                    : err_count_reg + CNT_W'(1);
                    end
                    if (win_err_inc >= THRESH) begin
                        state_next     = ST_SEED;
                        lock_lost_next = 1'b1;
                        sr_next        = '0;
                        seed_cnt_next  = '0;
                        win_cnt_next   = '0;
                        win_err_next   = '0;
                    end else if (win_cnt_reg == WIN_LAST) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + WIN_W'(1);
                        win_err_next = win_err_inc;
                    end
                end
                default: state_next = ST_SEED;
            endcase
        end

        if (clear) begin
            err_count_next = '0;
            bit_count_next = '0;
            lock_lost_next = 1'b0;
        end
    end

    assign locked_next = (state_next == ST_LOCKED);

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
    assign bit_count = bit_count_reg;
    assign lock_lost = lock_lost_reg;

endmodule

// File: tb/tb_prbs_stream_checker.sv
// Directed bench for prbs_stream_checker: a golden x^8+x^6+x^5+x^4+1 LFSR (seed 0x01)
// feeds the checker, with selected bits inverted, gapped, zeroed or interrupted by reset/clear.
module tb_prbs_stream_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] bit_count;
    logic        lock_lost;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] g;

    prbs_stream_checker #(
        .WIDTH(8), .TAPS(8'hB8), .WINDOW(64), .LOSS_THRESH(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .bit_count(bit_count), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        bit_valid = 1'b0;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present the next golden bit (optionally inverted); outputs sampled 1ns after the edge.
    task automatic drive_golden(input logic flip, input logic clr);
        logic fb;
        fb = ^(g & 8'hB8);
        g  = {g[6:0], fb};
        @(negedge clk);
        bit_in    = fb ^ flip;
        bit_valid = 1'b1;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bit_in    = 1'($urandom);
        bit_valid = 1'b0;
        clear     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_err_pulse: got %0b expected 0", err_pulse); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        vectors++; if (bit_count !== 16'd0) begin miscompares++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
        vectors++; if (lock_lost !== 1'b0) begin miscompares++; $display("FAIL reset_lock_lost: got %0b expected 0", lock_lost); end
        $display("test_reset done");
    endtask

    task automatic test_golden();
        int pulses = 0;
        do_reset();
        g = 8'h01;
        for (int i = 1; i <= 200; i++) begin
            drive_golden(1'b0, 1'b0);
            if (err_pulse === 1'b1) pulses++;
            if (i == 7) begin vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL golden_early_lock: got %0b expected 0", locked); end end
            if (i == 8) begin vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL golden_lock: got %0b expected 1", locked); end end
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL golden_pulses: got %0d expected 0", pulses); end
        vectors++; if (bit_count !== 16'd192) begin miscompares++; $display("FAIL golden_bit_count: got %0d expected 192", bit_count); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL golden_err_count: got %0d expected 0", err_count); end
        $display("test_golden: 200 bits, bit_count=%0d err_count=%0d", bit_count, err_count);
    endtask

    task automatic test_single_error();
        int pulses = 0;
        int pulse_at = -1;
        int unlocked = 0;
        do_reset();
        g = 8'h01;
        for (int i = 1; i <= 200; i++) begin
            drive_golden(i == 100, 1'b0);
            if (err_pulse === 1'b1) begin pulses++; pulse_at = i; end
            if (i >= 8 && locked !== 1'b1) unlocked++;
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
        vectors++; if (pulse_at != 100) begin miscompares++; $display("FAIL single_pulse_pos: got %0d expected 100", pulse_at); end
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL single_err_count: got %0d expected 1", err_count); end
        vectors++; if (unlocked != 0) begin miscompares++; $display("FAIL single_lock_held: got %0d unlocked cycles expected 0", unlocked); end
        $display("test_single_error: err_count=%0d pulse_at=%0d", err_count, pulse_at);
    endtask

    task automatic test_loss();
        do_reset();
        g = 8'h01;
        for (int i = 1; i <= 100; i++) begin
            drive_golden(i == 20 || i == 25 || i == 30 || i == 35, 1'b0);
            if (i == 34) begin vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL loss_pre: got %0b expected 1", locked); end end
            if (i == 35) begin
                vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL loss_drop: got %0b expected 0", locked); end
                vectors++; if (lock_lost !== 1'b1) begin miscompares++; $display("FAIL loss_sticky: got %0b expected 1", lock_lost); end
            end
            if (i == 42) begin vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL loss_early_relock: got %0b expected 0", locked); end end
            if (i == 43) begin vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL loss_relock: got %0b expected 1", locked); end end
        end
        vectors++; if (err_count !== 16'd4) begin miscompares++; $display("FAIL loss_err_count: got %0d expected 4", err_count); end
        vectors++; if (bit_count !== 16'd84) begin miscompares++; $display("FAIL loss_bit_count: got %0d expected 84", bit_count); end
        vectors++; if (lock_lost !== 1'b1) begin miscompares++; $display("FAIL loss_sticky_end: got %0b expected 1", lock_lost); end
        $display("test_loss: err_count=%0d bit_count=%0d lock_lost=%0b", err_count, bit_count, lock_lost);
    endtask

    task automatic test_zero_stream();
        int lock_seen = 0;
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            bit_in = 1'b0;
            bit_valid = 1'b1;
            @(posedge clk);
            #1;
            if (locked !== 1'b0) lock_seen++;
        end
        vectors++; if (lock_seen != 0) begin miscompares++; $display("FAIL zero_locked: got %0d locked cycles expected 0", lock_seen); end
        vectors++; if (bit_count !== 16'd0) begin miscompares++; $display("FAIL zero_bit_count: got %0d expected 0", bit_count); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL zero_err_count: got %0d expected 0", err_count); end
        $display("test_zero_stream: 100 zero bits, locked=%0b", locked);
    endtask

    task automatic test_gapped();
        int pulses = 0;
        do_reset();
        g = 8'h01;
        for (int i = 1; i <= 50; i++) begin
            drive_golden(1'b0, 1'b0);
            if (err_pulse === 1'b1) pulses++;
            if (i == 7) begin vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL gap_early_lock: got %0b expected 0", locked); end end
            if (i == 8) begin vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL gap_lock: got %0b expected 1", locked); end end
            drive_idle();
            if (err_pulse === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL gap_pulses: got %0d expected 0", pulses); end
        vectors++; if (bit_count !== 16'd42) begin miscompares++; $display("FAIL gap_bit_count: got %0d expected 42", bit_count); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL gap_err_count: got %0d expected 0", err_count); end
        $display("test_gapped: 50 valid bits, bit_count=%0d", bit_count);
    endtask

    task automatic test_async_reset();
        do_reset();
        g = 8'h01;
        for (int i = 1; i <= 30; i++) drive_golden(i == 20, 1'b0);
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL arst_pre_err: got %0d expected 1", err_count); end
        #3;
        rst = 1'b1;
        bit_valid = 1'b0;
        #1;
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL arst_locked: got %0b expected 0", locked); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL arst_err_count: got %0d expected 0", err_count); end
        vectors++; if (bit_count !== 16'd0) begin miscompares++; $display("FAIL arst_bit_count: got %0d expected 0", bit_count); end
        @(negedge clk);
        rst = 1'b0;
        g = 8'h01;
        for (int i = 1; i <= 20; i++) begin
            drive_golden(1'b0, 1'b0);
            if (i == 7) begin vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL arst_early_relock: got %0b expected 0", locked); end end
            if (i == 8) begin vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL arst_relock: got %0b expected 1", locked); end end
        end
        vectors++; if (bit_count !== 16'd12) begin miscompares++; $display("FAIL arst_bit_count_after: got %0d expected 12", bit_count); end
        $display("test_async_reset: relocked=%0b bit_count=%0d", locked, bit_count);
    endtask

    task automatic test_clear_on_error();
        do_reset();
        g = 8'h01;
        for (int i = 1; i <= 59; i++) drive_golden(i == 20 || i == 25 || i == 30 || i == 35, 1'b0);
        vectors++; if (lock_lost !== 1'b1) begin miscompares++; $display("FAIL clr_pre_lost: got %0b expected 1", lock_lost); end
        drive_golden(1'b1, 1'b1);
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL clr_err_count: got %0d expected 0", err_count); end
        vectors++; if (lock_lost !== 1'b0) begin miscompares++; $display("FAIL clr_lock_lost: got %0b expected 0", lock_lost); end
        vectors++; if (err_pulse !== 1'b1) begin miscompares++; $display("FAIL clr_err_pulse: got %0b expected 1", err_pulse); end
        vectors++; if (bit_count !== 16'd0) begin miscompares++; $display("FAIL clr_bit_count: got %0d expected 0", bit_count); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL clr_locked: got %0b expected 1", locked); end
        drive_golden(1'b0, 1'b0);
        vectors++; if (bit_count !== 16'd1) begin miscompares++; $display("FAIL clr_bit_count_next: got %0d expected 1", bit_count); end
        vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL clr_pulse_next: got %0b expected 0", err_pulse); end
        $display("test_clear_on_error: err_count=%0d lock_lost=%0b", err_count, lock_lost);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_single_error();
        test_loss();
        test_zero_stream();
        test_gapped();
        test_async_reset();
        test_clear_on_error();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
